dmem_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the single-port 4096-word data memory behind the processor.
- Port 0 is the core's load/store path (lw/sw).
- Port 1 is the loader/debug path, used to preload and dump memory.
- Grants one access at a time (round-robin), drives the memory macro, range-checks word addresses and returns one response per accepted request.

---
 rtl/dmem_arb_pkg.sv | 26 ++
 rtl/dmem_arbiter_rr_arb2.sv | 44 ++++
 rtl/dmem_arbiter.sv | 214 +++++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter slice.
// Optional statistics counters are enabled with DMEM_ARB_STATS_EN.
package dmem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      WAIT   = 2'd2,
      RESP   = 2'd3
   } arb_state_e;

   localparam logic PORT_CORE = 1'b0;
   localparam logic PORT_LOAD = 1'b1;

   localparam int unsigned DMEM_DEPTH = 4096;

   // The word address is signed, so any bit at or above aw (sign included) is out of range.
   function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned aw);
      return (addr >> aw) == 32'd0;
   endfunction

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin grant: combinational grant, registered last-grant update on accept.
module rr_arb2
   import dmem_arb_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic valid0,
   input  logic valid1,
   input  logic accept,
   output logic gnt0,
   output logic gnt1,
   output logic gnt_id
);

   logic last_grant_q;
   logic last_grant_d;

   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (valid0 && valid1) begin
         gnt0 = (last_grant_q == PORT_LOAD);
         gnt1 = (last_grant_q == PORT_CORE);
      end else begin
         gnt0 = valid0;
         gnt1 = valid1;
      end
      gnt_id = gnt1 ? PORT_LOAD : PORT_CORE;

      last_grant_d = last_grant_q;
      if (accept && (gnt0 || gnt1)) begin
         last_grant_d = gnt_id;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant_q <= PORT_LOAD;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and sequencer for the single-port data memory.
// Define DMEM_ARB_STATS_EN to add saturating grant / out-of-range counters.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W  = $clog2(DMEM_DEPTH),
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned MEM_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic              req0_we,
   input  logic [31:0]       req0_addr,
   input  logic [DATA_W-1:0] req0_wdata,
   output logic              rsp0_valid,
   output logic [DATA_W-1:0] rsp0_rdata,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic              req1_we,
   input  logic [31:0]       req1_addr,
   input  logic [DATA_W-1:0] req1_wdata,
   output logic              rsp1_valid,
   output logic [DATA_W-1:0] rsp1_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              oob_err,
   output logic              busy
`ifdef DMEM_ARB_STATS_EN
   ,
   output logic [15:0]       stat_grant0,
   output logic [15:0]       stat_grant1,
   output logic [15:0]       stat_oob
`endif
);

   localparam int unsigned CNT_W = 2;

   arb_state_e        state_q, state_d;
   logic              gnt0, gnt1, gnt_id;
   logic              grant;
   logic              we_q, we_d;
   logic [31:0]       addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              port_q, port_d;
   logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
   logic [DATA_W-1:0] rsp0_rdata_q, rsp0_rdata_d;
   logic [DATA_W-1:0] rsp1_rdata_q, rsp1_rdata_d;
   logic              in_rng;
   logic [DATA_W-1:0] rsp_data;

   rr_arb2 u_rr_arb2 (
      .clk    (clk),
      .rst    (rst),
      .valid0 (req0_valid),
      .valid1 (req1_valid),
      .accept (state_q == IDLE),
      .gnt0   (gnt0),
      .gnt1   (gnt1),
      .gnt_id (gnt_id)
   );

   assign grant    = (state_q == IDLE) && (gnt0 || gnt1);
   assign in_rng   = addr_in_range(addr_q, ADDR_W);
   assign rsp_data = (we_q || !in_rng) ? '0 : mem_rdata;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (gnt0 || gnt1) state_d = ACCESS;
         ACCESS:  state_d = (MEM_LAT > 1) ? WAIT : RESP;
         WAIT:    if (wait_cnt_q == '0) state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Request latch, latency counter and per-port response hold registers
   always_comb begin
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      port_d       = port_q;
      wait_cnt_d   = wait_cnt_q;
      rsp0_rdata_d = rsp0_rdata_q;
      rsp1_rdata_d = rsp1_rdata_q;

      if (grant) begin
         port_d = gnt_id;
         if (gnt_id == PORT_LOAD) begin
            we_d    = req1_we;
            addr_d  = req1_addr;
            wdata_d = req1_wdata;
         end else begin
            we_d    = req0_we;
            addr_d  = req0_addr;
            wdata_d = req0_wdata;
         end
      end

      if (state_q == ACCESS) begin
         wait_cnt_d = (MEM_LAT > 1) ? CNT_W'(MEM_LAT - 2) : '0;
      end else if ((state_q == WAIT) && (wait_cnt_q != '0)) begin
         wait_cnt_d = wait_cnt_q - 1'b1;
      end

      if (state_q == RESP) begin
         if (port_q == PORT_CORE) begin
            rsp0_rdata_d = rsp_data;
         end else begin
            rsp1_rdata_d = rsp_data;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         port_q       <= PORT_CORE;
         wait_cnt_q   <= '0;
         rsp0_rdata_q <= '0;
         rsp1_rdata_q <= '0;
      end else begin
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         port_q       <= port_d;
         wait_cnt_q   <= wait_cnt_d;
         rsp0_rdata_q <= rsp0_rdata_d;
         rsp1_rdata_q <= rsp1_rdata_d;
      end
   end

   // Outputs; read data arrives during RESP, so the response bypasses the hold register
   always_comb begin
      req0_ready = grant && gnt0 && !rst;
      req1_ready = grant && gnt1 && !rst;
      mem_en     = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      oob_err    = 1'b0;
      rsp0_valid = 1'b0;
      rsp1_valid = 1'b0;
      busy       = (state_q != IDLE);

      if (state_q == ACCESS) begin
         if (in_rng) begin
            mem_en    = 1'b1;
            mem_we    = we_q;
            mem_addr  = addr_q[ADDR_W-1:0];
            mem_wdata = wdata_q;
         end else begin
            oob_err = 1'b1;
         end
      end

      if (state_q == RESP) begin
         rsp0_valid = (port_q == PORT_CORE);
         rsp1_valid = (port_q == PORT_LOAD);
      end

      rsp0_rdata = rsp0_valid ? rsp_data : rsp0_rdata_q;
      rsp1_rdata = rsp1_valid ? rsp_data : rsp1_rdata_q;
   end

`ifdef DMEM_ARB_STATS_EN
   logic [15:0] stat_grant0_q, stat_grant0_d;
   logic [15:0] stat_grant1_q, stat_grant1_d;
   logic [15:0] stat_oob_q, stat_oob_d;

   always_comb begin
      stat_grant0_d = stat_grant0_q;
      stat_grant1_d = stat_grant1_q;
      stat_oob_d    = stat_oob_q;
      if (grant && gnt0) stat_grant0_d = sat_inc16(stat_grant0_q);
      if (grant && gnt1) stat_grant1_d = sat_inc16(stat_grant1_q);
      if (oob_err)       stat_oob_d    = sat_inc16(stat_oob_q);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_grant0_q <= '0;
         stat_grant1_q <= '0;
         stat_oob_q    <= '0;
      end else begin
         stat_grant0_q <= stat_grant0_d;
         stat_grant1_q <= stat_grant1_d;
         stat_oob_q    <= stat_oob_d;
      end
   end

   assign stat_grant0 = stat_grant0_q;
   assign stat_grant1 = stat_grant1_q;
   assign stat_oob    = stat_oob_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized self-checking bench for dmem_arbiter against a transaction-level model.
// Honours DMEM_ARB_STATS_EN when defined for both bench and design.
module tb_dmem_arbiter;

   parameter int MEM_LAT = 1;
   localparam int AW = 12;
   localparam int DEPTH = 4096;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req0_valid = 1'b0, req0_we = 1'b0;
   logic [31:0] req0_addr = '0, req0_wdata = '0;
   logic        req1_valid = 1'b0, req1_we = 1'b0;
   logic [31:0] req1_addr = '0, req1_wdata = '0;
   logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid;
   logic [31:0] rsp0_rdata, rsp1_rdata;
   logic        mem_en, mem_we, oob_err, busy;
   logic [AW-1:0] mem_addr;
   logic [31:0] mem_wdata, mem_rdata;
`ifdef DMEM_ARB_STATS_EN
   logic [15:0] stat_grant0, stat_grant1, stat_oob;
`endif

   always #5 clk = ~clk;

   dmem_arbiter #(.ADDR_W(AW), .DATA_W(32), .MEM_LAT(MEM_LAT)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
      .req0_addr(req0_addr), .req0_wdata(req0_wdata),
      .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
      .req1_addr(req1_addr), .req1_wdata(req1_wdata),
      .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .oob_err(oob_err), .busy(busy)
`ifdef DMEM_ARB_STATS_EN
      , .stat_grant0(stat_grant0), .stat_grant1(stat_grant1), .stat_oob(stat_oob)
`endif
   );

   // Memory macro: synchronous array with a MEM_LAT-deep read pipeline
   logic [31:0] mem_arr [DEPTH];
   logic [31:0] rd_pipe [MEM_LAT];
   assign mem_rdata = rd_pipe[MEM_LAT-1];

   always @(posedge clk) begin
      for (int i = MEM_LAT - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
      if (mem_en) begin
         if (mem_we) mem_arr[mem_addr] <= mem_wdata;
         else        rd_pipe[0] <= mem_arr[mem_addr];
      end
   end

   int total = 0;
   int bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h at t=%0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: expected memory contents plus the single outstanding transaction
   int          cyc = 0;
   logic [31:0] ref_mem [DEPTH];
   bit          last_g = 1'b1;
   bit          pend_v = 1'b0;
   bit          p_port, p_we, p_inr;
   logic [31:0] p_addr, p_wdata, p_exp;
   int          p_cyc;
   logic [31:0] last_rd0 = '0, last_rd1 = '0;
   int          gq[$];
   int          n_mem_en = 0, n_oob = 0;
   int          m_g0 = 0, m_g1 = 0, m_oob = 0;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      bit er0, er1;
      int age;
      if (rst) begin
         pend_v = 1'b0;
         last_g = 1'b1;
         last_rd0 = '0;
         last_rd1 = '0;
         m_g0 = 0; m_g1 = 0; m_oob = 0;
      end else begin
         er0 = 1'b0;
         er1 = 1'b0;
         if (!pend_v) begin
            if (req0_valid && req1_valid) begin
               er0 = last_g;
               er1 = !last_g;
            end else begin
               er0 = req0_valid;
               er1 = req1_valid;
            end
         end
         check("ready0", 32'(req0_ready), 32'(er0));
         check("ready1", 32'(req1_ready), 32'(er1));
         check("busy", 32'(busy), 32'(pend_v));
         if (mem_en) n_mem_en++;
         if (oob_err) n_oob++;

         age = pend_v ? (cyc - p_cyc) : -1;
         if (age == 1) begin
            check("mem_en", 32'(mem_en), 32'(p_inr));
            check("oob_err", 32'(oob_err), 32'(!p_inr));
            if (p_inr) begin
               check("mem_we", 32'(mem_we), 32'(p_we));
               check("mem_addr", 32'(mem_addr), 32'(p_addr[AW-1:0]));
               if (p_we) check("mem_wdata", mem_wdata, p_wdata);
            end
         end else begin
            check("mem_en_idle", 32'(mem_en), 32'd0);
            check("oob_idle", 32'(oob_err), 32'd0);
         end

         if (age == MEM_LAT + 1) begin
            check("rsp0_valid", 32'(rsp0_valid), 32'(!p_port));
            check("rsp1_valid", 32'(rsp1_valid), 32'(p_port));
            if (!p_port) begin
               check("rsp0_rdata", rsp0_rdata, p_exp);
               last_rd0 = p_exp;
               check("rsp1_hold", rsp1_rdata, last_rd1);
            end else begin
               check("rsp1_rdata", rsp1_rdata, p_exp);
               last_rd1 = p_exp;
               check("rsp0_hold", rsp0_rdata, last_rd0);
            end
            pend_v = 1'b0;
         end else begin
            check("rsp0_quiet", 32'(rsp0_valid), 32'd0);
            check("rsp1_quiet", 32'(rsp1_valid), 32'd0);
            check("rsp0_hold", rsp0_rdata, last_rd0);
            check("rsp1_hold", rsp1_rdata, last_rd1);
         end

         if (er0 || er1) begin
            pend_v  = 1'b1;
            p_port  = er1;
            p_we    = er1 ? req1_we : req0_we;
            p_addr  = er1 ? req1_addr : req0_addr;
            p_wdata = er1 ? req1_wdata : req0_wdata;
            p_cyc   = cyc;
            p_inr   = !p_addr[31] && (p_addr < DEPTH);
            p_exp   = '0;
            if (p_inr && p_we) ref_mem[p_addr[AW-1:0]] = p_wdata;
            if (p_inr && !p_we) p_exp = ref_mem[p_addr[AW-1:0]];
            if (!p_inr) m_oob++;
            if (er1) m_g1++; else m_g0++;
            last_g = er1;
            gq.push_back(er1 ? 1 : 0);
         end
      end
   end

   // hold == 0: keep valid until accepted; hold > 0: abandon after that many cycles
   task automatic drive(input bit p, input logic we, input logic [31:0] a,
                        input logic [31:0] d, input int hold);
      bit got;
      got = 1'b0;
      if (!p) begin
         req0_we = we; req0_addr = a; req0_wdata = d; req0_valid = 1'b1;
      end else begin
         req1_we = we; req1_addr = a; req1_wdata = d; req1_valid = 1'b1;
      end
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if ((!p && req0_ready) || (p && req1_ready)) begin
            got = 1'b1;
            break;
         end
         if (hold != 0 && k + 1 >= hold) break;
      end
      @(posedge clk);
      #1;
      if (!p) req0_valid = 1'b0; else req1_valid = 1'b0;
      if (hold == 0 && !got) check("accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_idle();
      bit idle;
      idle = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (!busy && !pend_v) begin
            idle = 1'b1;
            break;
         end
      end
      if (!idle) check("idle_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] rand_addr();
      case ($urandom_range(0, 7))
         0: return 32'hFFFF_FFFF;
         1: return 32'd4096;
         2: return 32'd4095;
         3: return $urandom;
         default: return 32'($urandom_range(0, 15));
      endcase
   endfunction

   task automatic rand_port(input bit p, input int n);
      for (int i = 0; i < n; i++) begin
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
         drive(p, 1'($urandom_range(0, 1)), rand_addr(), $urandom,
               ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0);
      end
   endtask

   initial begin
      int me0, oo0;
      for (int i = 0; i < DEPTH; i++) begin
         mem_arr[i] = $urandom;
         ref_mem[i] = mem_arr[i];
      end
      for (int i = 0; i < MEM_LAT; i++) rd_pipe[i] = '0;

      repeat (2) @(negedge clk);
      check("reset_ctl", {24'd0, req0_ready, req1_ready, rsp0_valid, rsp1_valid,
                          mem_en, mem_we, oob_err, busy}, 32'd0);
      check("reset_rd0", rsp0_rdata, 32'd0);
      check("reset_rd1", rsp1_rdata, 32'd0);
      #2 rst = 1'b0;
      @(posedge clk);
      #1;

      // Both ports contending from reset: port 0 wins the first tie, then alternate
      gq.delete();
      fork
         begin drive(0, 1'b0, 32'd1, '0, 0); drive(0, 1'b0, 32'd2, '0, 0); end
         begin drive(1, 1'b0, 32'd3, '0, 0); drive(1, 1'b0, 32'd4, '0, 0); end
      join
      wait_idle();
      check("rr_count", 32'(gq.size()), 32'd4);
      if (gq.size() == 4) begin
         check("rr_g0", 32'(gq[0]), 32'd0);
         check("rr_g1", 32'(gq[1]), 32'd1);
         check("rr_g2", 32'(gq[2]), 32'd0);
         check("rr_g3", 32'(gq[3]), 32'd1);
      end

      // Loader write then core read of the same word
      me0 = n_mem_en;
      drive(1, 1'b1, 32'd10, 32'h1234_5678, 0);
      drive(0, 1'b0, 32'd10, '0, 0);
      wait_idle();
      check("raw_rdata", rsp0_rdata, 32'h1234_5678);
      check("raw_mem_en", 32'(n_mem_en - me0), 32'd2);

      // Out-of-range reads never touch memory
      me0 = n_mem_en;
      oo0 = n_oob;
      drive(0, 1'b0, 32'hFFFF_FFFF, '0, 0);
      drive(0, 1'b0, 32'd4096, '0, 0);
      wait_idle();
      check("oob_pulses", 32'(n_oob - oo0), 32'd2);
      check("oob_mem_en", 32'(n_mem_en - me0), 32'd0);
      check("oob_rdata", rsp0_rdata, 32'd0);

      // Reset during the last cycle before the loader response
      drive(1, 1'b0, 32'd20, '0, 0);
      repeat (MEM_LAT - 1) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("rst_ctl", {24'd0, req0_ready, req1_ready, rsp0_valid, rsp1_valid,
                        mem_en, mem_we, oob_err, busy}, 32'd0);
      check("rst_mem", {20'd0, mem_addr}, 32'd0);
      check("rst_rd", rsp0_rdata | rsp1_rdata, 32'd0);
      repeat (2) @(negedge clk);
      #2 rst = 1'b0;
      @(posedge clk);
      #1;
      drive(0, 1'b0, 32'd10, '0, 0);
      wait_idle();
      check("post_rst_rd", rsp0_rdata, 32'h1234_5678);

      // Random contention with occasional abandoned requests
      fork
         rand_port(0, 40);
         rand_port(1, 40);
      join
      wait_idle();

`ifdef DMEM_ARB_STATS_EN
      check("stat_grant0", 32'(stat_grant0), 32'(m_g0));
      check("stat_grant1", 32'(stat_grant1), 32'(m_g1));
      check("stat_oob", 32'(stat_oob), 32'(m_oob));
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
